fib_hash_arbiter: RTL and testbench

FIB_HASH_ARBITER -- requirements
Module: fib_hash_arbiter

---
 rtl/fib_hash_arbiter.sv | 143 ++++++++++++++
 tb/tb_fib_hash_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fib_hash_arbiter.sv
// fib_hash_arbiter: round-robin arbiter that shares one hash engine between
// the FIB save path (port 0) and the FIB outgoing lookup path (port 1).
// One request is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Handshake: a requester holds reqN with stable prefixN/lenN until it sees
// the one-cycle gntN pulse, then drops reqN on the following cycle. A request
// still high when the FSM is back in IDLE is treated as a new request. The
// result arrives later as a one-cycle doneN pulse, with err qualifying it.
// The engine side is start/done: hash_start pulses once, hash_prefix/hash_len
// stay stable until the engine's hash_done pulse (or the timeout) is seen.
module fib_hash_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic [63:0] prefix0,
  input  logic [63:0] prefix1,
  input  logic [5:0]  len0,
  input  logic [5:0]  len1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic [9:0]  hash_out,
  output logic        err,
  output logic        hash_start,
  output logic [63:0] hash_prefix,
  output logic [5:0]  hash_len,
  input  logic        hash_done,
  input  logic [9:0]  hash_value,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Timer value at which an unanswered engine request is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        last_q;      // port served most recently
  logic        owner_q;     // port of the request in flight
  logic [7:0]  timer_q;
  logic        gnt0_q, gnt1_q, done0_q, done1_q, start_q, err_q;
  logic [9:0]  hash_out_q;
  logic [63:0] prefix_q;
  logic [5:0]  len_q;

  logic        win1;
  logic [7:0]  timer_d;
  logic        timeout_hit;

  // Winner selection and saturating timer increment.
  always_comb begin
    win1        = req1 & (~req0 | ~last_q);
    timer_d     = (timer_q == 8'hFF) ? timer_q : timer_q + 8'd1;
    timeout_hit = (timer_d == TMO_LAST);
  end

  // Arbitration FSM with registered outputs; pulses default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      last_q     <= 1'b1;
      owner_q    <= 1'b0;
      timer_q    <= 8'd0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      hash_out_q <= 10'd0;
      prefix_q   <= 64'd0;
      len_q      <= 6'd0;
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req0 | req1) begin
            owner_q  <= win1;
            prefix_q <= win1 ? prefix1 : prefix0;
            len_q    <= win1 ? len1 : len0;
            gnt0_q   <= ~win1;
            gnt1_q   <= win1;
            start_q  <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer_q <= 8'd0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // A completion on the timeout cycle still counts as success.
          if (hash_done) begin
            hash_out_q <= hash_value;
            err_q      <= 1'b0;
            done0_q    <= ~owner_q;
            done1_q    <= owner_q;
            state_q    <= ST_RESP;
          end else begin
            timer_q <= timer_d;
            if (timeout_hit) begin
              hash_out_q <= 10'd0;
              err_q      <= 1'b1;
              done0_q    <= ~owner_q;
              done1_q    <= owner_q;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          last_q  <= owner_q;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign hash_start  = start_q;
  assign err         = err_q;
  assign hash_out    = hash_out_q;
  assign hash_prefix = prefix_q;
  assign hash_len    = len_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fib_hash_arbiter.sv
// Directed bench for fib_hash_arbiter: single request, stray engine done,
// round-robin ties, timeout, coincident done/timeout, reset mid-WAIT.
module tb_fib_hash_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [63:0] prefix0, prefix1;
  logic [5:0]  len0, len1;
  logic        gnt0, gnt1, done0, done1;
  logic [9:0]  hash_out;
  logic        err, hash_start;
  logic [63:0] hash_prefix;
  logic [5:0]  hash_len;
  logic        hash_done;
  logic [9:0]  hash_value;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  fib_hash_arbiter #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0        (req0),
    .req1        (req1),
    .prefix0     (prefix0),
    .prefix1     (prefix1),
    .len0        (len0),
    .len1        (len1),
    .gnt0        (gnt0),
    .gnt1        (gnt1),
    .done0       (done0),
    .done1       (done1),
    .hash_out    (hash_out),
    .err         (err),
    .hash_start  (hash_start),
    .hash_prefix (hash_prefix),
    .hash_len    (hash_len),
    .hash_done   (hash_done),
    .hash_value  (hash_value),
    .dbg_state_o (dbg_state)
  );

  // Clock: 10 ns period.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_pulses"}, {gnt0, gnt1, done0, done1, hash_start}, 5'd0);
    check_eq({tag, "_err"}, err, 1'b0);
    check_eq({tag, "_hash_out"}, hash_out, 10'd0);
    check_eq({tag, "_hash_prefix"}, hash_prefix, 64'd0);
    check_eq({tag, "_hash_len"}, hash_len, 6'd0);
    check_eq({tag, "_state"}, dbg_state, 2'd0);
  endtask

  // Wait (bounded) for a grant; port = -1 if none arrives.
  task automatic wait_gnt(output int port);
    port = -1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (gnt0 | gnt1) begin
        port = gnt1 ? 1 : 0;
        break;
      end
    end
  endtask

  initial begin
    int port;
    int cyc;
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    prefix0 = 64'd0; prefix1 = 64'd0; len0 = 6'd0; len1 = 6'd0;
    hash_done = 1'b0; hash_value = 10'd0;

    // Reset state.
    #1;
    check_all_zero("reset");
    @(posedge clk); @(posedge clk); #4;
    rst = 1'b1;
    tick();

    // Single request with a one-cycle engine.
    req0 = 1'b1; prefix0 = 64'h0123456789ABCDEF; len0 = 6'd20;
    tick();  // cycle N+1
    check_eq("single_gnt", {gnt1, gnt0}, 2'b01);
    check_eq("single_start", hash_start, 1'b1);
    check_eq("single_prefix", hash_prefix, 64'h0123456789ABCDEF);
    check_eq("single_len", hash_len, 6'd20);
    req0 = 1'b0;
    tick();  // cycle N+2
    check_eq("single_gnt_pulse", {gnt1, gnt0, hash_start}, 3'b000);
    check_eq("single_no_early_done", {done1, done0}, 2'b00);
    hash_done = 1'b1; hash_value = 10'h2A5;
    tick();  // cycle N+3
    hash_done = 1'b0;
    check_eq("single_done", {done1, done0}, 2'b01);
    check_eq("single_hash_out", hash_out, 10'h2A5);
    check_eq("single_err", err, 1'b0);
    check_eq("single_len_hold", hash_len, 6'd20);
    tick();
    check_eq("single_done_pulse", {done1, done0}, 2'b00);

    // Stray hash_done while idle.
    hash_done = 1'b1; hash_value = 10'h111;
    tick();
    hash_done = 1'b0;
    check_eq("stray_done", {done1, done0}, 2'b00);
    tick();
    check_eq("stray_done2", {done1, done0}, 2'b00);
    check_eq("stray_hash_out", hash_out, 10'h2A5);

    // Round robin with both requests held high from reset.
    rst = 1'b0; #2; rst = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    prefix0 = 64'hAAAA; prefix1 = 64'hBBBB; len0 = 6'd8; len1 = 6'd16;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(port);
      check_eq("rr_order", port, i % 2);
      check_eq("rr_gnt_excl", gnt0 & gnt1, 1'b0);
      check_eq("rr_len", hash_len, (i % 2) ? 6'd16 : 6'd8);
      tick();
      hash_done = 1'b1; hash_value = 10'h100 + 10'(i);
      tick();
      hash_done = 1'b0;
      check_eq("rr_done", {done1, done0}, (i % 2) ? 2'b10 : 2'b01);
      check_eq("rr_hash_out", hash_out, 10'h100 + 10'(i));
      if (i == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
    end

    // Timeout on port 1: done1 exactly 16 cycles after gnt1.
    req1 = 1'b1; prefix1 = 64'hFEED; len1 = 6'd7;
    tick();
    check_eq("tmo_gnt", {gnt1, gnt0}, 2'b10);
    req1 = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done1 | done0) begin
        cyc = k;
        break;
      end
    end
    check_eq("tmo_latency", cyc, 16);
    check_eq("tmo_done_port", {done1, done0}, 2'b10);
    check_eq("tmo_err", err, 1'b1);
    check_eq("tmo_hash_out", hash_out, 10'd0);
    tick();

    // hash_done coinciding with the timeout cycle wins.
    req0 = 1'b1; prefix0 = 64'h1234; len0 = 6'd33;
    tick();
    check_eq("coin_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check_eq("coin_no_early_done", {done1, done0}, 2'b00);
    end
    hash_done = 1'b1; hash_value = 10'h3FF;
    tick();
    hash_done = 1'b0;
    check_eq("coin_done", {done1, done0}, 2'b01);
    check_eq("coin_err", err, 1'b0);
    check_eq("coin_hash_out", hash_out, 10'h3FF);
    tick();

    // Reset during WAIT for port 0.
    req0 = 1'b1; prefix0 = 64'h5555; len0 = 6'd12;
    tick();
    check_eq("rstw_gnt", {gnt1, gnt0}, 2'b01);
    req0 = 1'b0;
    tick();
    tick();
    check_eq("rstw_in_wait", dbg_state, 2'd2);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("rstw");
    req1 = 1'b1; prefix1 = 64'h7777; len1 = 6'd3;
    #1;
    rst = 1'b1;
    tick();
    check_eq("rstw_gnt1", {gnt1, gnt0}, 2'b10);
    check_eq("rstw_len", hash_len, 6'd3);
    req1 = 1'b0;
    tick();
    hash_done = 1'b1; hash_value = 10'h055;
    tick();
    hash_done = 1'b0;
    check_eq("rstw_done", {done1, done0}, 2'b10);
    check_eq("rstw_hash_out", hash_out, 10'h055);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
